// File: rtl/legv8_mem_pkg.sv
// Shared types, constants and helpers for the LEGv8 data-memory load/store path.
package legv8_mem_pkg;

   // Default number of strobe cycles tolerated without mem_ack before abort.
   localparam int TIMEOUT_CYC_DEF = 16;

   // Access size encoding carried on req_size.
   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10,
      SIZE_D = 2'b11
   } lsuSize_t;

   // Load/store unit control states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } lsuState_t;

   // Right-justified data mask for each access size, indexed by lsuSize_t.
   localparam logic [63:0] SIZE_MASK [4] = '{
      64'h0000_0000_0000_00FF,
      64'h0000_0000_0000_FFFF,
      64'h0000_0000_FFFF_FFFF,
      64'hFFFF_FFFF_FFFF_FFFF
   };

   // Data mask for an access of the given size.
   function automatic logic [63:0] sizeMask(input lsuSize_t size);
      return SIZE_MASK[size];
   endfunction

   // An access is misaligned when any address bit below its size is set.
   function automatic logic isMisaligned(input logic [2:0] offset, input lsuSize_t size);
      logic [2:0] lowMask;
      case (size)
         SIZE_B:  lowMask = 3'b000;
         SIZE_H:  lowMask = 3'b001;
         SIZE_W:  lowMask = 3'b011;
         SIZE_D:  lowMask = 3'b111;
         default: lowMask = 3'b111;
      endcase
      return |(offset & lowMask);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit: extracts and extends a load
// result from a doubleword, and merges sub-doubleword store data into the
// old doubleword for read-modify-write. Purely combinational.
module lsu_lane_align
   import legv8_mem_pkg::*;
(
   input  logic [63:0] rdata,
   input  lsuSize_t    size,
   input  logic        signExt,
   input  logic [2:0]  offset,
   input  logic [63:0] wdata,
   output logic [63:0] loadData,
   output logic [63:0] mergeData
);

   logic [5:0]  shamtS;
   logic [63:0] maskS;
   logic [63:0] laneS;
   logic [63:0] laneMaskS;
   logic        signBitS;

   // Little-endian lane extraction, sign/zero extension and store merge.
   always_comb begin
      shamtS    = {offset, 3'b000};
      maskS     = sizeMask(size);
      laneS     = (rdata >> shamtS) & maskS;

      // Top bit of the accessed field; a full doubleword never needs extension.
      case (size)
         SIZE_B:  signBitS = laneS[7];
         SIZE_H:  signBitS = laneS[15];
         SIZE_W:  signBitS = laneS[31];
         SIZE_D:  signBitS = 1'b0;
         default: signBitS = 1'b0;
      endcase

      if (signExt && signBitS) begin
         loadData = laneS | ~maskS;
      end else begin
         loadData = laneS;
      end

      laneMaskS = maskS << shamtS;
      mergeData = (rdata & ~laneMaskS) | ((wdata << shamtS) & laneMaskS);
   end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory interface. Accepts one load/store at a
// time, drives doubleword read/write strobes, performs read-modify-write for
// byte/half/word stores and reports misalignment or memory timeout.
module load_store_unit
   import legv8_mem_pkg::*;
#(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Counter holds 0..TIMEOUT_CYC-1; the last value triggers the abort.
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   lsuState_t         stateR;
   logic              writeR;
   lsuSize_t          sizeR;
   logic              signedR;
   logic [2:0]        offsetR;
   logic [DATA_W-1:0] wdataR;
   logic [CNT_W-1:0]  timeoutCntR;

   lsuSize_t          reqSizeS;
   logic              reqMisalignedS;
   logic [DATA_W-1:0] loadDataS;
   logic [DATA_W-1:0] mergeDataS;

   // Ready only while idle and not being reset.
   assign req_ready = (stateR == IDLE) && !reset;

   // Decode the incoming request's size and alignment.
   always_comb begin
      reqSizeS       = lsuSize_t'(req_size);
      reqMisalignedS = isMisaligned(req_addr[2:0], reqSizeS);
   end

   // Lane steering works on the raw memory read data so the result can be
   // captured on the same edge that sees mem_ack.
   lsu_lane_align uAlign (
      .rdata     (mem_rdata),
      .size      (sizeR),
      .signExt   (signedR),
      .offset    (offsetR),
      .wdata     (wdataR),
      .loadData  (loadDataS),
      .mergeData (mergeDataS)
   );

   // Control FSM with registered strobes, response and timeout counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateR      <= IDLE;
         writeR      <= 1'b0;
         sizeR       <= SIZE_B;
         signedR     <= 1'b0;
         offsetR     <= 3'b000;
         wdataR      <= '0;
         timeoutCntR <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_data    <= '0;
      end else begin
         case (stateR)
            IDLE: begin
               if (req_valid && req_ready) begin
                  writeR      <= req_write;
                  sizeR       <= reqSizeS;
                  signedR     <= req_signed;
                  offsetR     <= req_addr[2:0];
                  wdataR      <= req_wdata;
                  timeoutCntR <= '0;
                  mem_addr    <= {req_addr[ADDR_W-1:3], 3'b000};
                  if (reqMisalignedS) begin
                     // Never touch memory for an illegal access.
                     stateR    <= RESP;
                     mem_wdata <= '0;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                  end else if (req_write && (reqSizeS == SIZE_D)) begin
                     stateR    <= WR;
                     mem_write <= 1'b1;
                     mem_wdata <= req_wdata;
                  end else begin
                     // Loads and partial stores both start with a read.
                     stateR    <= RD;
                     mem_read  <= 1'b1;
                     mem_wdata <= '0;
                  end
               end
            end

            RD: begin
               if (mem_ack) begin
                  mem_read    <= 1'b0;
                  timeoutCntR <= '0;
                  if (writeR) begin
                     stateR    <= WR;
                     mem_write <= 1'b1;
                     mem_wdata <= mergeDataS;
                  end else begin
                     stateR    <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_data  <= loadDataS;
                  end
               end else if (timeoutCntR == CNT_LAST) begin
                  mem_read  <= 1'b0;
                  stateR    <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= '0;
               end else begin
                  timeoutCntR <= timeoutCntR + 1'b1;
               end
            end

            WR: begin
               if (mem_ack) begin
                  mem_write <= 1'b0;
                  stateR    <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= '0;
               end else if (timeoutCntR == CNT_LAST) begin
                  mem_write <= 1'b0;
                  stateR    <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= '0;
               end else begin
                  timeoutCntR <= timeoutCntR + 1'b1;
               end
            end

            RESP: begin
               stateR    <= IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_data  <= '0;
            end

            default: begin
               stateR    <= IDLE;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_data  <= '0;
            end
         endcase
      end
   end

endmodule
